tone_sequencer: RTL

- Plays a stored note table on the tone generator without CPU involvement per note.
- Holds a note RAM of DEPTH entries; each entry is a divisor word plus a duration.
- Steps through the entries and drives the generator's divisor and enable inputs, with an optional silent gap between notes and an optional loop.
- Sits between the AXI4-Lite register slave, which loads the table and issues start/stop, and the tone generator core.

---
 rtl/tone_sequencer_if.sv | 29 ++
 rtl/tone_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer_if.sv
// Note-table load/control bus from the register slave and tone generator drive bus.
interface tone_sequencer_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_WIDTH  = 20,
    parameter int DUR_WIDTH  = 12
);
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DIV_WIDTH-1:0]  wr_div;
    logic [DUR_WIDTH-1:0]  wr_dur;
    logic                  start;
    logic                  stop;
    logic                  loop;
    logic [DIV_WIDTH-1:0]  tone_div;
    logic                  tone_en;
    logic                  busy;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic                  done;

    modport master (
        output wr_en, wr_addr, wr_div, wr_dur, start, stop, loop,
        input  tone_div, tone_en, busy, cur_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_div, wr_dur, start, stop, loop,
        output tone_div, tone_en, busy, cur_idx, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a DEPTH-entry note table onto the tone generator; first note 2 edges after start.
// No backpressure: writes accepted every cycle, stop takes effect on the next edge.
module tone_sequencer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_WIDTH  = 20,
    parameter int DUR_WIDTH  = 12,
    parameter int TICK_DIV   = 50000,
    parameter int GAP_TICKS  = 10
) (
    input logic             ACLK,
    input logic             ARESETN,
    tone_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DUR_WIDTH-1:0]  GAP_LAST   = DUR_WIDTH'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX   = DEPTH_LOG2'(DEPTH - 1);

    typedef struct packed {
        logic [DIV_WIDTH-1:0] div;
        logic [DUR_WIDTH-1:0] dur;
    } note_t;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    note_t mem [DEPTH];
    note_t rd;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;
    logic [DUR_WIDTH-1:0]  dur_q, dur_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [DUR_WIDTH-1:0]  tick_q, tick_d;
    logic                  tick_end;
    logic                  advance;

    // Combinational read against a clocked write gives read-first behaviour.
    always_ff @(posedge ACLK) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= '{div: bus.wr_div, dur: bus.wr_dur};
        end
    end

    assign rd       = mem[idx_q];
    assign tick_end = (presc_q == PRESC_LAST);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            dur_q   <= '0;
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            en_q    <= en_d;
            done_q  <= done_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        en_d    = en_q;
        done_d  = 1'b0;
        dur_d   = dur_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end else if (rd.dur != '0) begin
                    state_d = PLAY;
                    div_d   = rd.div;
                    en_d    = (rd.div != '0);
                    dur_d   = rd.dur;
                    presc_d = '0;
                    tick_d  = '0;
                end else if (bus.loop && idx_q != '0) begin
                    idx_d = '0;
                end else begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end else begin
                    presc_d = tick_end ? '0 : presc_q + 1'b1;
                    tick_d  = tick_q + DUR_WIDTH'(tick_end);
                    // Compare against dur-1 so a full-scale duration never wraps the counter.
                    if (tick_end && tick_q == dur_q - 1'b1) begin
                        if (GAP_TICKS > 0) begin
                            state_d = GAP;
                            en_d    = 1'b0;
                            presc_d = '0;
                            tick_d  = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end else begin
                    presc_d = tick_end ? '0 : presc_q + 1'b1;
                    tick_d  = tick_q + DUR_WIDTH'(tick_end);
                    if (tick_end && tick_q == GAP_LAST) begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            en_d = 1'b0;
            if (idx_q != LAST_IDX) begin
                state_d = FETCH;
                idx_d   = idx_q + 1'b1;
            end else if (bus.loop) begin
                state_d = FETCH;
                idx_d   = '0;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    assign bus.tone_div = div_q;
    assign bus.tone_en  = en_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.cur_idx  = idx_q;
    assign bus.done     = done_q;
endmodule
